// File: rtl/acs_unit.sv
// Add-compare-select stage for the K=3, rate-1/2 Viterbi decoder (g1=111, g0=101).
// Updates four path metrics per valid symbol and reports the survivor decisions
// and the index of the best state.
module acs_unit #(
    parameter int unsigned PM_W    = 6,
    parameter int unsigned INIT_PM = 2**(PM_W-2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                sop,
    input  logic [1:0]          bm00,
    input  logic [1:0]          bm01,
    input  logic [1:0]          bm10,
    input  logic [1:0]          bm11,
    output logic                out_valid,
    output logic [3:0]          dec_bits,
    output logic [1:0]          best_state,
    output logic [4*PM_W-1:0]   pm_out
);

    // Sums carry one extra bit so the add cannot wrap before normalisation.
    localparam int unsigned SW = PM_W + 1;
    localparam logic [SW-1:0]   HALF = SW'(2**(PM_W-1));
    localparam logic [SW-1:0]   FULL = SW'(2**PM_W);
    localparam logic [PM_W-1:0] SAT  = {PM_W{1'b1}};
    localparam logic [PM_W-1:0] INIT = PM_W'(INIT_PM);

    logic [PM_W-1:0] r_pm [4];
    logic            r_valid;
    logic [3:0]      r_dec;
    logic [1:0]      r_best;

    logic [PM_W-1:0] w_base   [4];
    logic [SW-1:0]   w_cand_u [4];
    logic [SW-1:0]   w_cand_l [4];
    logic [SW-1:0]   w_sel    [4];
    logic [SW-1:0]   w_adj    [4];
    logic [PM_W-1:0] w_new    [4];
    logic [3:0]      w_dec;
    logic            w_norm;
    logic [PM_W-1:0] w_min;
    logic [1:0]      w_best;

    // Starting metrics: a frame start replaces history with the reset metrics.
    always_comb begin
        w_base[0] = sop ? '0 : r_pm[0];
        for (int i = 1; i < 4; i++) begin
            w_base[i] = sop ? INIT : r_pm[i];
        end
    end

    // Candidate sums; upper predecessor is {ns[0],0}, lower is {ns[0],1}.
    always_comb begin
        w_cand_u[0] = {1'b0, w_base[0]} + SW'(bm00);
        w_cand_l[0] = {1'b0, w_base[1]} + SW'(bm11);
        w_cand_u[1] = {1'b0, w_base[2]} + SW'(bm10);
        w_cand_l[1] = {1'b0, w_base[3]} + SW'(bm01);
        w_cand_u[2] = {1'b0, w_base[0]} + SW'(bm11);
        w_cand_l[2] = {1'b0, w_base[1]} + SW'(bm00);
        w_cand_u[3] = {1'b0, w_base[2]} + SW'(bm01);
        w_cand_l[3] = {1'b0, w_base[3]} + SW'(bm10);
    end

    // Compare-select (ties keep the upper path), then normalise and saturate.
    always_comb begin
        w_norm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_dec[i] = (w_cand_l[i] < w_cand_u[i]);
            w_sel[i] = w_dec[i] ? w_cand_l[i] : w_cand_u[i];
            if (w_sel[i] < HALF) begin
                w_norm = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            w_adj[i] = w_norm ? (w_sel[i] - HALF) : w_sel[i];
            w_new[i] = (w_adj[i] >= FULL) ? SAT : w_adj[i][PM_W-1:0];
        end
    end

    // Best state: smallest new metric, lowest index on ties.
    always_comb begin
        w_min  = w_new[0];
        w_best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (w_new[i] < w_min) begin
                w_min  = w_new[i];
                w_best = 2'(i);
            end
        end
    end

    // Metric and output registers; hold when no symbol is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pm[0] <= '0;
            for (int i = 1; i < 4; i++) begin
                r_pm[i] <= INIT;
            end
            r_valid <= 1'b0;
            r_dec   <= '0;
            r_best  <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) begin
                    r_pm[i] <= w_new[i];
                end
                r_dec  <= w_dec;
                r_best <= w_best;
            end
        end
    end

    assign out_valid  = r_valid;
    assign dec_bits   = r_dec;
    assign best_state = r_best;
    assign pm_out     = {r_pm[3], r_pm[2], r_pm[1], r_pm[0]};

endmodule

// File: tb/tb_acs_unit.sv
// Bench for acs_unit: constant-expectation table, hand-built corner sequences,
// and randomized symbols checked against a trellis-level reference model.
module tb_acs_unit;

    localparam int PM_W = 6;
    localparam int INIT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        sop;
    logic [1:0]  bm00, bm01, bm10, bm11;
    logic        out_valid;
    logic [3:0]  dec_bits;
    logic [1:0]  best_state;
    logic [23:0] pm_out;

    acs_unit #(.PM_W(PM_W), .INIT_PM(INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .sop        (sop),
        .bm00       (bm00),
        .bm01       (bm01),
        .bm10       (bm10),
        .bm11       (bm11),
        .out_valid  (out_valid),
        .dec_bits   (dec_bits),
        .best_state (best_state),
        .pm_out     (pm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int       m_pm [4];
    bit [3:0] m_dec;
    int       m_best;
    bit       m_ov;

    typedef struct {
        bit        v;
        bit        s;
        bit [1:0]  b00, b01, b10, b11;
        bit        ov;
        bit [3:0]  dec;
        bit [1:0]  best;
        bit [23:0] pm;
    } vec_t;

    localparam int NROWS = 28;
    vec_t tbl [NROWS];

    function automatic bit [23:0] pm4(input int p3, input int p2, input int p1, input int p0);
        return {6'(p3), 6'(p2), 6'(p1), 6'(p0)};
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        for (int i = 1; i < 4; i++) m_pm[i] = INIT;
        m_dec  = '0;
        m_best = 0;
        m_ov   = 1'b0;
    endtask

    // Trellis-rule model: ns={u,s1}, pred={s1,s0}, codeword {u^s1^s0, u^s0}.
    task automatic model_step(input bit v, input bit s, input int b00, input int b01,
                              input int b10, input int b11);
        int base [4];
        int nw   [4];
        int bmv  [4];
        int u, s1, pred, cw, c, bc;
        bit all_hi;
        if (!v) begin
            m_ov = 1'b0;
            return;
        end
        bmv = '{b00, b01, b10, b11};
        if (s) base = '{0, INIT, INIT, INIT};
        else   base = m_pm;
        for (int ns = 0; ns < 4; ns++) begin
            u  = ns / 2;
            s1 = ns % 2;
            bc = 0;
            for (int s0 = 0; s0 < 2; s0++) begin
                pred = s1 * 2 + s0;
                cw   = (((u ^ s1 ^ s0) & 1) << 1) | ((u ^ s0) & 1);
                c    = base[pred] + bmv[cw];
                if (s0 == 0 || c < bc) begin
                    bc         = c;
                    m_dec[ns]  = s0[0];
                end
            end
            nw[ns] = bc;
        end
        all_hi = 1'b1;
        for (int i = 0; i < 4; i++) if (nw[i] < 32) all_hi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (all_hi) nw[i] -= 32;
            if (nw[i] >= 64) nw[i] = 63;
        end
        m_best = 0;
        for (int i = 1; i < 4; i++) if (nw[i] < nw[m_best]) m_best = i;
        m_pm = nw;
        m_ov = 1'b1;
    endtask

    task automatic check(input string name, input bit e_ov, input bit [3:0] e_dec,
                         input bit [1:0] e_best, input bit [23:0] e_pm);
        n_vec++;
        if (out_valid !== e_ov || dec_bits !== e_dec || best_state !== e_best || pm_out !== e_pm) begin
            n_err++;
            $display("FAIL %s: got ov=%0b dec=%b best=%0d pm={%0d,%0d,%0d,%0d} want ov=%0b dec=%b best=%0d pm={%0d,%0d,%0d,%0d}",
                     name, out_valid, dec_bits, best_state,
                     pm_out[23:18], pm_out[17:12], pm_out[11:6], pm_out[5:0],
                     e_ov, e_dec, e_best, e_pm[23:18], e_pm[17:12], e_pm[11:6], e_pm[5:0]);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_ov, m_dec, 2'(m_best), pm4(m_pm[3], m_pm[2], m_pm[1], m_pm[0]));
    endtask

    // Drive inputs on the falling edge; return just after the next rising edge.
    task automatic drive(input bit v, input bit s, input int b00, input int b01,
                         input int b10, input int b11);
        @(negedge clk);
        in_valid = v;
        sop      = s;
        bm00     = 2'(b00);
        bm01     = 2'(b01);
        bm10     = 2'(b10);
        bm11     = 2'(b11);
        @(posedge clk);
        #1;
        model_step(v, s, b00, b01, b10, b11);
    endtask

    initial begin
        bit v, s;
        int b0, b1, b2, b3, gap;

        // Rows 0..9: idle after reset; 10: noiseless zero; 11: sop without valid;
        // 12: sop restart with all bm=2; 13..27: all bm=2 up to symbol 16.
        for (int r = 0; r < 10; r++)
            tbl[r] = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 2'd0, pm4(16, 16, 16, 0)};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2, 1'b1, 4'b0000, 2'd0, pm4(17, 2, 17, 0)};
        tbl[11] = '{1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 4'b0000, 2'd0, pm4(17, 2, 17, 0)};
        tbl[12] = '{1'b1, 1'b1, 2'd2, 2'd2, 2'd2, 2'd2, 1'b1, 4'b0000, 2'd0, pm4(18, 2, 18, 2)};
        for (int k = 2; k <= 16; k++) begin
            int e;
            e = (k == 16) ? 0 : 2 * k;
            tbl[11 + k] = '{1'b1, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2, 1'b1, 4'b0000, 2'd0, pm4(e, e, e, e)};
        end

        rst = 1'b1; in_valid = 1'b0; sop = 1'b0;
        bm00 = '0; bm01 = '0; bm10 = '0; bm11 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 4'b0000, 2'd0, pm4(16, 16, 16, 0));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int r = 0; r < NROWS; r++) begin
            drive(tbl[r].v, tbl[r].s, tbl[r].b00, tbl[r].b01, tbl[r].b10, tbl[r].b11);
            check($sformatf("tbl[%0d]", r), tbl[r].ov, tbl[r].dec, tbl[r].best, tbl[r].pm);
        end

        // Frame restart: 5 random symbols, then sop with the noiseless-zero metrics.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 2));
            check_model($sformatf("pre_sop[%0d]", i));
        end
        drive(1'b1, 1'b1, 0, 1, 1, 2);
        check("sop_restart", 1'b1, 4'b0000, 2'd0, pm4(17, 2, 17, 0));
        drive(1'b0, 1'b1, 2, 2, 2, 2);
        check("sop_no_valid", 1'b0, 4'b0000, 2'd0, pm4(17, 2, 17, 0));

        // Tie-break with gaps: restart with all bm=2 gives pm0=pm2=2 minimal.
        drive(1'b1, 1'b1, 2, 2, 2, 2);
        check("tie_best0", 1'b1, 4'b0000, 2'd0, pm4(18, 2, 18, 2));
        for (int g = 1; g <= 3; g++) begin
            for (int j = 0; j < g; j++) begin
                drive(1'b0, 1'b0, 1, 0, 2, 1);
                check($sformatf("gap%0d_idle%0d", g, j), 1'b0, 4'b0000, 2'd0, pm4(18, 2, 18, 2));
            end
        end
        drive(1'b1, 1'b0, 0, 0, 0, 0);
        check_model("after_gaps");

        // Randomized symbols with gaps and occasional frame starts.
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 15) == 0);
            b0 = $urandom_range(0, 2);
            b1 = $urandom_range(0, 2);
            b2 = $urandom_range(0, 2);
            b3 = $urandom_range(0, 2);
            drive(v, s, b0, b1, b2, b3);
            check_model($sformatf("rand[%0d]", i));
        end

        // Async reset between edges while symbols stream back-to-back.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, $urandom_range(0, 2), 1, 1, $urandom_range(0, 2));
        end
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 1'b0, 4'b0000, 2'd0, pm4(16, 16, 16, 0));
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 0, 1, 1, 2);
        check("post_reset_sym", 1'b1, 4'b0000, 2'd0, pm4(17, 2, 17, 0));
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        check("post_reset_idle", 1'b0, 4'b0000, 2'd0, pm4(17, 2, 17, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
